// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared AES definitions: FSM encodings, the GF(2^8) reduction constant and xtime.
// The forward mix_columns path imports the same package.
package inv_mix_columns_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] AES_REDUCE = 8'h1B;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns of one 32-bit column; byte 0 is the column MSB.
module inv_mix_column
    import inv_mix_columns_iter_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_b  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mB [4];
    logic [7:0] w_mD [4];
    logic [7:0] w_mE [4];

    // The four inverse coefficients are built from x, x^2 and x^3 of each byte.
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign w_b[i]  = i_col[31-8*i -: 8];
        assign w_x2[i] = xtime(w_b[i]);
        assign w_x4[i] = xtime(w_x2[i]);
        assign w_x8[i] = xtime(w_x4[i]);
        assign w_m9[i] = w_x8[i] ^ w_b[i];
        assign w_mB[i] = w_x8[i] ^ w_x2[i] ^ w_b[i];
        assign w_mD[i] = w_x8[i] ^ w_x4[i] ^ w_b[i];
        assign w_mE[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
    end

    assign o_col[31:24] = w_mE[0] ^ w_mB[1] ^ w_mD[2] ^ w_m9[3];
    assign o_col[23:16] = w_m9[0] ^ w_mE[1] ^ w_mB[2] ^ w_mD[3];
    assign o_col[15:8]  = w_mD[0] ^ w_m9[1] ^ w_mE[2] ^ w_mB[3];
    assign o_col[7:0]   = w_mB[0] ^ w_mD[1] ^ w_m9[2] ^ w_mE[3];

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns over a 128-bit AES state: one column per cycle through
// a single shared column unit, with a valid/ready handshake on both sides.
module inv_mix_columns_iter
    import inv_mix_columns_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    state_t       r_state;
    state_t       w_nextState;
    logic [1:0]   r_colIdx;
    logic [127:0] r_work;
    logic [31:0]  w_colIn;
    logic [31:0]  w_colOut;
    logic         w_accept;

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_colIdx == 2'd3) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_colIn = r_work[127:96];
        case (r_colIdx)
            2'd0: w_colIn = r_work[127:96];
            2'd1: w_colIn = r_work[95:64];
            2'd2: w_colIn = r_work[63:32];
            2'd3: w_colIn = r_work[31:0];
            default: w_colIn = r_work[127:96];
        endcase
    end

    inv_mix_column u_invCol (
        .i_col (w_colIn),
        .o_col (w_colOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The column counter wraps 3->0 exactly on the BUSY->DONE step, so each
    // column is rewritten in place once per block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work   <= '0;
            r_colIdx <= 2'd0;
        end else if (w_accept) begin
            r_work   <= in_state;
            r_colIdx <= 2'd0;
        end else if (r_state == ST_BUSY) begin
            case (r_colIdx)
                2'd0: r_work[127:96] <= w_colOut;
                2'd1: r_work[95:64]  <= w_colOut;
                2'd2: r_work[63:32]  <= w_colOut;
                2'd3: r_work[31:0]   <= w_colOut;
                default: r_work[127:96] <= w_colOut;
            endcase
            r_colIdx <= r_colIdx + 2'd1;
        end
    end

    // Gate the working register so a partially transformed block is never visible.
    assign out_state = (r_state == ST_DONE) ? r_work : '0;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter: directed vectors, back-pressure,
// mid-flight reset, back-to-back blocks and a forward/inverse round trip.
module tb_inv_mix_columns_iter;

    localparam logic [127:0] V028_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V028_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V029_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V029_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;

    int           testsRun = 0;
    int           failCount = 0;
    logic [127:0] sbQueue [$];
    logic [127:0] sbExpected;
    time          lastHsTime = 0;

    inv_mix_columns_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference arithmetic: plain shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mixColumnsModel(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b0, b1, b2, b3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {b0, b1, b2, b3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {
                gfMul(b0, 8'h02) ^ gfMul(b1, 8'h03) ^ b2 ^ b3,
                b0 ^ gfMul(b1, 8'h02) ^ gfMul(b2, 8'h03) ^ b3,
                b0 ^ b1 ^ gfMul(b2, 8'h02) ^ gfMul(b3, 8'h03),
                gfMul(b0, 8'h03) ^ b1 ^ b2 ^ gfMul(b3, 8'h02)};
        end
        return r;
    endfunction

    // Sampled on the falling edge: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            lastHsTime = $time + 5;
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnderflow", 128'(sbQueue.size()), 128'd1);
            end else begin
                sbExpected = sbQueue.pop_front();
                checkOutput("result", out_state, sbExpected);
            end
        end
    end

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] expected,
                                 input bit keepValid, output time acceptTime);
        bit done;
        bit rdy;
        done       = 1'b0;
        acceptTime = 0;
        in_valid   = 1'b1;
        in_state   = data;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done       = 1'b1;
                acceptTime = $time;
                sbQueue.push_back(expected);
            end
            #1;
        end
        if (!keepValid) in_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 128'(done), 128'd1);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 100 && sbQueue.size() != 0; i++) waitEdge();
        checkOutput(tag, 128'(sbQueue.size()), 128'd0);
    endtask

    initial begin
        time tAcc;
        time tB;
        logic [127:0] orig;
        bit seen;

        rst = 1'b1;
        repeat (2) waitEdge();
        checkOutput("rstOutValid", 128'(out_valid), 128'd0);
        checkOutput("rstOutState", out_state, 128'd0);
        rst = 1'b0;
        #1;
        checkOutput("rstInReady", 128'(in_ready), 128'd1);

        // Latency: result valid on the fourth edge after acceptance.
        out_ready = 1'b1;
        applyStimulus(V028_IN, V028_OUT, 1'b0, tAcc);
        checkOutput("busyInReady", 128'(in_ready), 128'd0);
        for (int k = 1; k <= 4; k++) begin
            waitEdge();
            checkOutput($sformatf("latValid%0d", k), 128'(out_valid), 128'(k == 4));
            checkOutput($sformatf("latInReady%0d", k), 128'(in_ready), 128'd0);
        end
        waitEdge();
        checkOutput("hsClear", 128'(out_valid), 128'd0);
        waitDrain("drain028");

        applyStimulus(V029_IN, V029_OUT, 1'b0, tAcc);
        waitDrain("drain029");

        // Back-pressure while the producer keeps offering other data.
        out_ready = 1'b0;
        applyStimulus(V028_IN, V028_OUT, 1'b0, tAcc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            waitEdge();
            seen = out_valid;
        end
        checkOutput("bpValidSeen", 128'(seen), 128'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            waitEdge();
            checkOutput("bpHold", out_state, V028_OUT);
            checkOutput("bpInReady", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain("drainBp");

        // Reset after two columns: block discarded, outputs cleared immediately.
        applyStimulus(V029_IN, V029_OUT, 1'b0, tAcc);
        waitEdge();
        waitEdge();
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 128'(out_valid), 128'd0);
        checkOutput("midRstState", out_state, 128'd0);
        sbQueue.delete();
        waitEdge();
        rst = 1'b0;
        #1;
        checkOutput("postRstInReady", 128'(in_ready), 128'd1);
        applyStimulus(V029_IN, V029_OUT, 1'b0, tAcc);
        waitDrain("drainRst");

        // Back-to-back: second block accepted the edge after the first handshake.
        applyStimulus(V028_IN, V028_OUT, 1'b1, tAcc);
        applyStimulus(V029_IN, V029_OUT, 1'b0, tB);
        checkOutput("b2bGap", 128'(tB - lastHsTime), 128'd10);
        waitDrain("drainB2b");

        // Round trip through the reference forward transform.
        for (int n = 0; n < 1000; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(mixColumnsModel(orig), orig, 1'b0, tAcc);
        end
        waitDrain("drainRandom");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 SHALL have no parameters; data width fixed at 128-bit AES state (4 columns x 4 bytes).
REQ-002 SHALL run on one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  in_state holds a block to transform.
REQ-006 in_ready  output  1  block can accept input this cycle.
REQ-007 in_state  input  128  state; column k = bits [127-32k -: 32], byte b0 = MSB of column.
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 out_state  output  128  InvMixColumns(in_state), same column/byte layout.

Function
REQ-011 SHALL compute per column: c0=0e*b0^0b*b1^0d*b2^09*b3; c1=09*b0^0e*b1^0b*b2^0d*b3; c2=0d*b0^09*b1^0e*b2^0b*b3; c3=0b*b0^0d*b1^09*b2^0e*b3.
REQ-012 GF(2^8) multiplies SHALL use xtime with reduction polynomial 0x11B (XOR 0x1B on MSB carry); 09=x8^x, 0b=x8^x2^x, 0d=x8^x4^x, 0e=x8^x4^x2.
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, register in_state, clear 2-bit column counter, go BUSY.
REQ-015 BUSY: each cycle transform column[counter] in the working register in place, counter+1; after column 3 go DONE.
REQ-016 DONE: out_valid=1, out_state = working register, stable until out_ready; on out_valid&out_ready go IDLE.
REQ-017 Latency: out_valid SHALL rise on the 4th rising edge after the accepting edge.
REQ-018 in_ready SHALL be 0 in BUSY and DONE; in_valid and in_state ignored there.
REQ-019 Counter SHALL wrap 3->0 only on BUSY->DONE; no column transformed twice.
REQ-020 out_ready with out_valid=0 SHALL have no effect.
REQ-021 Back-pressure: DONE SHALL hold indefinitely with out_state unchanged while out_ready=0.
REQ-022 Outputs SHALL be registered or decoded directly from FSM state; no combinational path from in_* to out_*.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, counter=0, working register=0, out_valid=0, out_state=0, in_ready=1 after release.
REQ-024 rst asserted in BUSY or DONE SHALL discard the block in flight; no partial result ever presented.
REQ-025 First accept possible on first rising edge with rst=0.

Structure
REQ-026 Shared AES package/include SHALL hold FSM state encodings, the 0x1B reduction constant and the xtime function; reused by the forward mix_columns path.
REQ-027 SHALL instantiate one combinational sub-module inv_mix_column (4 bytes in, 4 bytes out) implementing REQ-011/012, shared across all four columns.

Verification
REQ-028 in_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1 -> out_valid 4 edges after accept, out_state=128'hdb135345_f20a225c_01010101_c6c6c6c6, in_ready low meanwhile.
REQ-029 in_state=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff -> out_state=128'hd4d4d4d5_2d26314c_00000000_ffffffff.
REQ-030 Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_state constant, in_ready=0; in_valid toggling with other data ignored; result from REQ-028 delivered on out_ready=1.
REQ-031 Reset mid-BUSY (after 2 columns) -> out_valid=0, out_state=0 at once; next block REQ-029 yields correct result with no residue.
REQ-032 Round-trip: 1000 random states through forward mix_columns then inv_mix_columns_iter -> output equals original every time.
REQ-033 Back-to-back: in_valid held high with two blocks, out_ready=1 -> both results correct, in order, second accepted the cycle after first result handshake.
